// File: rtl/led_ip_pkg.sv
// Shared LED IP definitions: FSM state enum, ctrl mode encodings, register indices
// and the ctrl-word decode used by the pattern core.
package led_ip_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_STATIC   = 2'd1,
    ST_BLINK    = 2'd2,
    ST_SHIFT    = 2'd3
  } led_state_e;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SHIFT  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int unsigned REG_CTRL    = 0;
  localparam int unsigned REG_PERIOD  = 1;
  localparam int unsigned REG_PATTERN = 2;
  localparam int unsigned REG_DUTY    = 3;

  // Reserved mode 11 falls back to static.
  function automatic led_state_e decode_ctrl(input logic enable, input logic [1:0] mode);
    if (!enable) return ST_DISABLED;
    case (mode)
      MODE_BLINK: return ST_BLINK;
      MODE_SHIFT: return ST_SHIFT;
      default:    return ST_STATIC;
    endcase
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Prescaler plus period counter: tick every PRESCALE cycles while enabled,
// step on the tick that completes max(period,1) ticks.
module led_step_timer #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] period,
  output logic        tick,
  output logic        step
);

  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;
  logic [15:0]   pcnt_q;
  logic [15:0]   pmax;

  always_comb begin
    pmax = (period == '0) ? '0 : period - 16'd1;
    tick = en && !clr && !rst && (presc_q == LAST);
    // >= keeps the counter bounded if period shrinks mid-count
    step = tick && (pcnt_q >= pmax);
  end

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (presc_q == LAST) begin
      presc_q <= '0;
      pcnt_q  <= (pcnt_q >= pmax) ? '0 : pcnt_q + 16'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_core.sv
// LED pattern engine: disabled/static/blink/shift modes driven from AXI-Lite register
// values. Optional PWM dimming enabled by defining LED_PATTERN_PWM_EN.
module led_pattern_core
  import led_ip_pkg::*;
#(
  parameter int unsigned NUM_LEDS           = 4,
  parameter int unsigned PRESCALE           = 50000,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_ctrl,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_period,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_pattern,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cfg_duty,
  input  logic                          cfg_wr_strobe,
  output logic [NUM_LEDS-1:0]           led,
  output logic                          tick,
  output logic [1:0]                    state
);

  led_state_e          state_q, state_d;
  logic                restart;
  logic                step;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] pattern;
  logic [NUM_LEDS-1:0] shreg_q, shreg_d;
  logic [NUM_LEDS-1:0] led_d;
  logic [NUM_LEDS-1:0] led_gated;
  logic                unused_cfg_bits;

  assign pattern         = cfg_pattern[NUM_LEDS-1:0];
  assign state           = state_q;
  assign unused_cfg_bits = ^{cfg_ctrl, cfg_period, cfg_pattern, cfg_duty};

  led_step_timer #(
    .PRESCALE(PRESCALE)
  ) u_step_timer (
    .clk   (ACLK),
    .rst   (ARESET),
    .en    (state_q != ST_DISABLED),
    .clr   (restart),
    .period(cfg_period[15:0]),
    .tick  (tick),
    .step  (step)
  );

  // led is registered from next-cycle values so a config change shows after one edge.
  always_comb begin
    state_d = decode_ctrl(cfg_ctrl[0], cfg_ctrl[2:1]);
    restart = cfg_wr_strobe || (state_d != state_q);
    phase_d = phase_q;
    shreg_d = shreg_q;
    if (restart) begin
      phase_d = 1'b0;
      shreg_d = pattern;
    end else if (step) begin
      phase_d = ~phase_q;
      shreg_d = (shreg_q << 1) | (shreg_q >> (NUM_LEDS - 1));
    end
    led_d = '0;
    case (state_d)
      ST_STATIC: led_d = pattern;
      ST_BLINK:  led_d = phase_d ? pattern : '0;
      ST_SHIFT:  led_d = shreg_d;
      default:   led_d = '0;
    endcase
  end

`ifdef LED_PATTERN_PWM_EN
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  always_ff @(posedge ACLK) begin
    if (ARESET) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on    = (pwm_cnt < cfg_duty[7:0]) || (cfg_duty[7:0] == 8'hFF);
  assign led_gated = led_d & {NUM_LEDS{pwm_on}};
`else
  assign led_gated = led_d;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_DISABLED;
      phase_q <= 1'b0;
      shreg_q <= '0;
      led     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      led     <= led_gated;
    end
  end

endmodule

// File: doc/led_pattern_core.md
LED_PATTERN_CORE -- requirements
Module: led_pattern_core

Interface
- REQ-001: The module SHALL have parameter NUM_LEDS, default 4, giving the LED output width (1..32).
- REQ-002: The module SHALL have parameter PRESCALE, default 50000, giving ACLK cycles per tick (>=2).
- REQ-003: The module SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the config word width.
- REQ-004: ACLK  input  1  single clock; all logic on its rising edge.
- REQ-005: ARESET  input  1  synchronous, active-high reset.
- REQ-006: cfg_ctrl  input  32  register 0 value: bit0 enable, bits[2:1] mode (00 static, 01 blink, 10 shift, 11 treated as static).
- REQ-007: cfg_period  input  32  register 1 value: bits[15:0] ticks per step; 0 is treated as 1.
- REQ-008: cfg_pattern  input  32  register 2 value: bits[NUM_LEDS-1:0] LED pattern.
- REQ-009: cfg_duty  input  32  register 3 value: bits[7:0] PWM duty.
- REQ-010: cfg_wr_strobe  input  1  one-cycle pulse on any AXI4-Lite register write.
- REQ-011: led  output  NUM_LEDS  registered LED drive.
- REQ-012: tick  output  1  one-cycle pulse at each prescaler wrap.
- REQ-013: state  output  2  current FSM state, for status readback.

Function
- REQ-014: FSM states SHALL be DISABLED=0, STATIC=1, BLINK=2, SHIFT=3.
- REQ-015: Every cycle: enable=0 selects DISABLED from any state; otherwise mode selects STATIC, BLINK or SHIFT.
- REQ-016: Any state change, and any cfg_wr_strobe, SHALL clear prescaler, period counter and blink phase, and load the shift register from cfg_pattern on the next edge.
- REQ-017: Prescaler SHALL count 0..PRESCALE-1 when not DISABLED, hold at 0 in DISABLED, and assert tick for the cycle in which it wraps.
- REQ-018: Period counter SHALL advance on tick and raise an internal step when it reaches max(cfg_period[15:0],1)-1, then wrap to 0.
- REQ-019: DISABLED: led SHALL be all zeros.
- REQ-020: STATIC: led SHALL equal cfg_pattern[NUM_LEDS-1:0], one-cycle latency from input change.
- REQ-021: BLINK: phase SHALL toggle on each step; led = pattern when phase=1, zero when phase=0; phase starts at 0.
- REQ-022: SHIFT: shift register SHALL rotate left by one position on each step (MSB wraps to LSB); led = shift register.
- REQ-023: If cfg_wr_strobe and a step coincide, the strobe SHALL win (reload, no step applied).
- REQ-024: Arithmetic SHALL be unsigned; counters SHALL never exceed their stated bounds.

Reset
- REQ-025: While ARESET=1: state=DISABLED, led=0, tick=0, all counters, phase and shift register = 0.
- REQ-026: Reset asserted mid-pattern SHALL take effect on the next edge; after release, operation restarts from REQ-016 conditions.

Configuration
- REQ-027: Macro LED_PATTERN_PWM_EN, when defined, SHALL add a free-running 8-bit PWM counter (reset 0) and gate led bitwise with (pwm_cnt < cfg_duty[7:0]) OR (cfg_duty[7:0]==8'hFF).
- REQ-028: Without LED_PATTERN_PWM_EN, no PWM logic SHALL exist and cfg_duty SHALL be ignored.

Structure
- REQ-029: A shared package led_ip_pkg SHALL hold the state enum, mode encodings, and register-index constants (0 ctrl, 1 period, 2 pattern, 3 duty).
- REQ-030: The prescaler+period counter SHALL be a sub-module led_step_timer producing tick and step.

Verification (bench uses NUM_LEDS=4, PRESCALE=2)
- REQ-031: Reset, then ctrl=0x1, pattern=0x5 -> state=1, led=0x5 one cycle after inputs settle.
- REQ-032: ctrl=0x3, period=2, pattern=0xF, strobe -> led 0x0 for 4 cycles, then 0xF for 4 cycles, repeating.
- REQ-033: ctrl=0x5, period=1, pattern=0x9, strobe -> led sequence 0x9, 0x3, 0x6, 0xC, 0x9, changing every 2 cycles.
- REQ-034: SHIFT running, strobe coinciding with step -> led reloads to pattern, no rotation that cycle; ARESET mid-run -> led=0, state=0 next edge.
- REQ-035: period=0 behaves identically to period=1; ctrl=0x7 behaves as STATIC.
- REQ-036: With LED_PATTERN_PWM_EN, STATIC 0xF, duty=0x40 -> each LED high 64 of every 256 cycles; duty=0x00 -> always off; duty=0xFF -> always on.
